// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and FSM encoding for the instruction fetch slice
package fetch_pkg;

   localparam int INST_W = 32;
   localparam int PC_INC = 4;

   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_RUN   = 2'd1,
      S_HALT  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/inst_rom.sv
// rtl/inst_rom.sv - synchronous single-port read-only instruction memory, DEPTH x XLEN
// Contents come from the elaboration-time image; there is no write path.
module inst_rom
   import fetch_pkg::*;
#(
   parameter int                    XLEN       = INST_W,
   parameter int                    DEPTH      = 64,
   parameter                        INIT_FILE  = "inst.hex",
   parameter logic [DEPTH*XLEN-1:0] INIT_IMAGE = '0,
   localparam int                   AW         = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            en,
   input  logic [AW-1:0]   addr,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] rdata_d;
   logic [XLEN-1:0] rdata_q;

   // Holding the read register while disabled keeps the word stable across stalls.
   always_comb begin
      rdata_d = rdata_q;
      if (en) begin
         rdata_d = INIT_IMAGE[int'(addr)*XLEN +: XLEN];
      end
   end

   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC sequencer with stall, redirect and sticky fault over inst_rom
// fetch_pc_q is the next PC to issue; inst_pc/inst_code belong to the word issued last.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    XLEN       = INST_W,
   parameter int                    DEPTH      = 64,
   parameter logic [XLEN-1:0]       RESET_PC   = '0,
   parameter                        INIT_FILE  = "inst.hex",
   parameter logic [DEPTH*XLEN-1:0] INIT_IMAGE = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_code,
   output logic [XLEN-1:0] inst_pc,
   output logic            fault
);

   localparam int AW = $clog2(DEPTH);

   fetch_state_e    state_q,      state_d;
   logic [XLEN-1:0] fetch_pc_q,   fetch_pc_d;
   logic [XLEN-1:0] inst_pc_q,    inst_pc_d;
   logic            inst_valid_q, inst_valid_d;
   logic            fault_q,      fault_d;
   logic            rom_en;
   logic            fetch_oob;
   logic            redirect_bad;

   assign fetch_oob    = (fetch_pc_q >> (AW + 2)) != '0;
   assign redirect_bad = (redirect_pc[1:0] != 2'b00) || ((redirect_pc >> (AW + 2)) != '0);

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      fault_d      = fault_q;
      rom_en       = 1'b0;
      unique case (state_q)
         S_START, S_RUN: begin
            if (state_q == S_RUN && redirect_valid) begin
               // Squash the in-flight word; the target is issued next cycle.
               inst_valid_d = 1'b0;
               if (redirect_bad) begin
                  state_d = S_HALT;
                  fault_d = 1'b1;
               end else begin
                  fetch_pc_d = redirect_pc;
               end
            end else if (state_q == S_START || !stall || !inst_valid_q) begin
               if (fetch_oob) begin
                  state_d      = S_HALT;
                  fault_d      = 1'b1;
                  inst_valid_d = 1'b0;
               end else begin
                  rom_en       = 1'b1;
                  state_d      = S_RUN;
                  inst_pc_d    = fetch_pc_q;
                  inst_valid_d = 1'b1;
                  fetch_pc_d   = fetch_pc_q + XLEN'(PC_INC);
               end
            end
         end
         default: begin
            state_d      = S_HALT;
            inst_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_START;
         fetch_pc_q   <= RESET_PC;
         inst_pc_q    <= RESET_PC;
         inst_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         fault_q      <= fault_d;
      end
   end

   inst_rom #(
      .XLEN      (XLEN),
      .DEPTH     (DEPTH),
      .INIT_FILE (INIT_FILE),
      .INIT_IMAGE(INIT_IMAGE)
   ) u_rom (
      .clk  (clk),
      .en   (rom_en),
      .addr (fetch_pc_q[2 +: AW]),
      .rdata(inst_code)
   );

   assign inst_valid = inst_valid_q;
   assign inst_pc    = inst_pc_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed bench for inst_fetch_unit, image word k = 0x1000_0000 + k
module tb_inst_fetch_unit;

   localparam int XLEN  = 32;
   localparam int DEPTH = 64;

   function automatic logic [DEPTH*XLEN-1:0] make_image();
      logic [DEPTH*XLEN-1:0] img;
      img = '0;
      for (int k = 0; k < DEPTH; k++) begin
         img[k*XLEN +: XLEN] = 32'h1000_0000 + 32'(k);
      end
      return img;
   endfunction

   localparam logic [DEPTH*XLEN-1:0] IMAGE = make_image();

   logic            clk;
   logic            rst;
   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic [XLEN-1:0] inst_code;
   logic [XLEN-1:0] inst_pc;
   logic            fault;

   int checks;
   int failures;

   inst_fetch_unit #(
      .XLEN      (XLEN),
      .DEPTH     (DEPTH),
      .RESET_PC  (32'h0),
      .INIT_FILE ("inst.hex"),
      .INIT_IMAGE(IMAGE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .inst_valid    (inst_valid),
      .inst_code     (inst_code),
      .inst_pc       (inst_pc),
      .fault         (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk_inst(input string tag, input logic [31:0] pc, input logic [31:0] code);
      chk({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
      chk({tag, ".pc"}, inst_pc, pc);
      chk({tag, ".code"}, inst_code, code);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      chk("reset.valid", {31'd0, inst_valid}, 32'd0);
      chk("reset.fault", {31'd0, fault}, 32'd0);
      chk("reset.pc", inst_pc, 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      rst            = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // Sequential fetch from reset, then a 3-cycle stall on pc 8.
      do_reset();
      chk("start.valid", {31'd0, inst_valid}, 32'd0);
      step(); chk_inst("seq0", 32'h0, 32'h1000_0000);
      step(); chk_inst("seq1", 32'h4, 32'h1000_0001);
      step(); chk_inst("seq2", 32'h8, 32'h1000_0002);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); chk_inst("stall", 32'h8, 32'h1000_0002);
      end
      stall = 1'b0;
      step(); chk_inst("unstall", 32'hC, 32'h1000_0003);
      step(); chk_inst("seq4", 32'h10, 32'h1000_0004);

      // Redirect and stall together: redirect wins.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h20;
      stall          = 1'b1;
      step(); chk("redstall.squash", {31'd0, inst_valid}, 32'd0);
      redirect_valid = 1'b0;
      stall          = 1'b0;
      step(); chk_inst("redstall.tgt", 32'h20, 32'h1000_0008);

      // Plain redirect taken while inst_pc = 4.
      do_reset();
      step(); chk_inst("r.seq0", 32'h0, 32'h1000_0000);
      step(); chk_inst("r.seq1", 32'h4, 32'h1000_0001);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step(); chk("redir.squash", {31'd0, inst_valid}, 32'd0);
      redirect_valid = 1'b0;
      step(); chk_inst("redir.tgt", 32'h40, 32'h1000_0010);
      step(); chk_inst("redir.next", 32'h44, 32'h1000_0011);

      // Misaligned redirect halts with a sticky fault; reset clears it.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h22;
      step();
      chk("misal.fault", {31'd0, fault}, 32'd1);
      chk("misal.valid", {31'd0, inst_valid}, 32'd0);
      redirect_pc = 32'h10;
      step();
      redirect_valid = 1'b0;
      step(); step();
      chk("halt.fault", {31'd0, fault}, 32'd1);
      chk("halt.valid", {31'd0, inst_valid}, 32'd0);
      do_reset();
      step(); chk_inst("restart", 32'h0, 32'h1000_0000);
      chk("restart.fault", {31'd0, fault}, 32'd0);

      // Run off the top of memory: 0xFC delivered, then fault on 0x100.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hF0;
      step(); chk("top.squash", {31'd0, inst_valid}, 32'd0);
      redirect_valid = 1'b0;
      step(); chk_inst("top.f0", 32'hF0, 32'h1000_003C);
      step(); chk_inst("top.f4", 32'hF4, 32'h1000_003D);
      step(); chk_inst("top.f8", 32'hF8, 32'h1000_003E);
      step(); chk_inst("top.fc", 32'hFC, 32'h1000_003F);
      chk("top.fc.fault", {31'd0, fault}, 32'd0);
      step();
      chk("top.oob.fault", {31'd0, fault}, 32'd1);
      chk("top.oob.valid", {31'd0, inst_valid}, 32'd0);

      // Aligned but out-of-range redirect also faults.
      do_reset();
      step(); chk_inst("oobr.seq0", 32'h0, 32'h1000_0000);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      step();
      redirect_valid = 1'b0;
      chk("oobr.fault", {31'd0, fault}, 32'd1);
      chk("oobr.valid", {31'd0, inst_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
